dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the single-port data memory.
// Each access takes three cycles: IDLE grant, ACCESS memory strobe, RESP pulse.
module dmem_arbiter #(
  parameter int ADDR_WORDS = 40,
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic        p0_req_we,
  input  logic [31:0] p0_req_addr,
  input  logic [31:0] p0_req_wdata,
  input  logic [2:0]  p0_req_func3,
  output logic        p0_resp_valid,
  output logic [31:0] p0_resp_rdata,
  output logic        p0_resp_err,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_req_we,
  input  logic [31:0] p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  input  logic [2:0]  p1_req_func3,
  output logic        p1_resp_valid,
  output logic [31:0] p1_resp_rdata,
  output logic        p1_resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_func3,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] ADDR_LIMIT = 32'(ADDR_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  logic        ptr;
  logic        win;
  logic        err;

  logic        any_valid;
  logic        grant_p1;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_func3;
  logic        sel_err;

  // Pick the winning port and mux its request fields.
  always_comb begin
    any_valid = p0_req_valid | p1_req_valid;
    if (FIXED_PRIO != 0) begin
      grant_p1 = ~p0_req_valid;
    end else if (p0_req_valid && p1_req_valid) begin
      grant_p1 = ptr;
    end else begin
      grant_p1 = ~p0_req_valid;
    end
    if (grant_p1) begin
      sel_we    = p1_req_we;
      sel_addr  = p1_req_addr;
      sel_wdata = p1_req_wdata;
      sel_func3 = p1_req_func3;
    end else begin
      sel_we    = p0_req_we;
      sel_addr  = p0_req_addr;
      sel_wdata = p0_req_wdata;
      sel_func3 = p0_req_func3;
    end
    sel_err = (sel_addr >= ADDR_LIMIT) || (sel_func3 > 3'b010);
  end

  // Ready is gated by rst_n so every output is low while reset is held.
  assign p0_req_ready = rst_n && (state == IDLE) && any_valid && !grant_p1;
  assign p1_req_ready = rst_n && (state == IDLE) && any_valid && grant_p1;

  // Sequencer FSM; memory strobes and responses are driven straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      win           <= 1'b0;
      err           <= 1'b0;
      mem_addr      <= 32'd0;
      mem_wdata     <= 32'd0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_func3     <= 3'd0;
      p0_resp_valid <= 1'b0;
      p0_resp_rdata <= 32'd0;
      p0_resp_err   <= 1'b0;
      p1_resp_valid <= 1'b0;
      p1_resp_rdata <= 32'd0;
      p1_resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            win   <= grant_p1;
            err   <= sel_err;
            state <= ACCESS;
            if (sel_err) begin
              mem_addr  <= 32'd0;
              mem_wdata <= 32'd0;
              mem_func3 <= 3'd0;
              mem_read  <= 1'b0;
              mem_write <= 1'b0;
            end else begin
              mem_addr  <= sel_addr;
              mem_wdata <= sel_wdata;
              mem_func3 <= sel_func3;
              mem_read  <= ~sel_we;
              mem_write <= sel_we;
            end
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          p0_resp_valid <= ~win;
          p0_resp_err   <= ~win & err;
          p0_resp_rdata <= (!win && mem_read) ? mem_rdata : 32'd0;
          p1_resp_valid <= win;
          p1_resp_err   <= win & err;
          p1_resp_rdata <= (win && mem_read) ? mem_rdata : 32'd0;
          mem_addr      <= 32'd0;
          mem_wdata     <= 32'd0;
          mem_func3     <= 3'd0;
          mem_read      <= 1'b0;
          mem_write     <= 1'b0;
          state         <= RESP;
        end
        RESP: begin
          p0_resp_valid <= 1'b0;
          p0_resp_rdata <= 32'd0;
          p0_resp_err   <= 1'b0;
          p1_resp_valid <= 1'b0;
          p1_resp_rdata <= 32'd0;
          p1_resp_err   <= 1'b0;
          ptr           <= (FIXED_PRIO != 0) ? 1'b0 : ~win;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-level timing model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req_valid = 1'b0, p0_req_we = 1'b0;
  logic [31:0] p0_req_addr = 32'd0, p0_req_wdata = 32'd0;
  logic [2:0]  p0_req_func3 = 3'd0;
  logic        p1_req_valid = 1'b0, p1_req_we = 1'b0;
  logic [31:0] p1_req_addr = 32'd0, p1_req_wdata = 32'd0;
  logic [2:0]  p1_req_func3 = 3'd0;
  logic        p0_req_ready, p0_resp_valid, p0_resp_err;
  logic        p1_req_ready, p1_resp_valid, p1_resp_err;
  logic [31:0] p0_resp_rdata, p1_resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;
  logic [2:0]  mem_func3;

  logic        fx_p0_valid = 1'b0, fx_p1_valid = 1'b0;
  logic        fx_p0_ready, fx_p1_ready, fx_p0_rv, fx_p1_rv, fx_p0_err, fx_p1_err;
  logic [31:0] fx_p0_rdata, fx_p1_rdata, fx_mem_addr, fx_mem_wdata, fx_mem_rdata;
  logic        fx_mem_read, fx_mem_write;
  logic [2:0]  fx_mem_func3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(.ADDR_WORDS(40), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_func3(p0_req_func3),
    .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata), .p0_resp_err(p0_resp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_func3(p1_req_func3),
    .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata), .p1_resp_err(p1_resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ADDR_WORDS(40), .FIXED_PRIO(1)) dut_fx (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(fx_p0_valid), .p0_req_ready(fx_p0_ready), .p0_req_we(1'b0),
    .p0_req_addr(32'd2), .p0_req_wdata(32'd0), .p0_req_func3(3'b010),
    .p0_resp_valid(fx_p0_rv), .p0_resp_rdata(fx_p0_rdata), .p0_resp_err(fx_p0_err),
    .p1_req_valid(fx_p1_valid), .p1_req_ready(fx_p1_ready), .p1_req_we(1'b0),
    .p1_req_addr(32'd3), .p1_req_wdata(32'd0), .p1_req_func3(3'b010),
    .p1_resp_valid(fx_p1_rv), .p1_resp_rdata(fx_p1_rdata), .p1_resp_err(fx_p1_err),
    .mem_addr(fx_mem_addr), .mem_wdata(fx_mem_wdata), .mem_read(fx_mem_read),
    .mem_write(fx_mem_write), .mem_func3(fx_mem_func3), .mem_rdata(fx_mem_rdata)
  );
  assign fx_mem_rdata = fx_mem_addr + 32'h100;

  function automatic logic [31:0] lane(input logic [31:0] w, input logic [2:0] f);
    case (f)
      3'b000:  lane = {{24{w[7]}}, w[7:0]};
      3'b001:  lane = {{16{w[15]}}, w[15:0]};
      default: lane = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [2:0] f);
    case (f)
      3'b000:  merge = {o[31:8], n[7:0]};
      3'b001:  merge = {o[31:16], n[15:0]};
      default: merge = n;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Environment memory: 40 words, combinational read, write on the clock edge.
  logic [31:0] mem [0:39];
  logic [31:0] ref_mem [0:39];
  always_comb begin
    mem_rdata = 32'd0;
    if (mem_addr < 32'd40) mem_rdata = lane(mem[mem_addr[5:0]], mem_func3);
  end
  always @(posedge clk)
    if (rst_n && mem_write && mem_addr < 32'd40)
      mem[mem_addr[5:0]] <= merge(mem[mem_addr[5:0]], mem_wdata, mem_func3);

  // Timing model: a grant at cycle c gives the strobe at c+1, the response at c+2
  // and frees the arbiter at c+3; only one access is ever in flight.
  int m_cyc = -1, r_cyc = -1, free_at = 0;
  bit ptr_m = 1'b0;
  logic m_rd, m_wr, r_port, r_err, e_r0, e_r1, w, we;
  logic [31:0] m_addr, m_wdata, r_rdata, a;
  logic [2:0] m_f3, f;
  bit er;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_cyc = -1; r_cyc = -1; free_at = 0; ptr_m = 1'b0;
      chk("rst p0_ready", {31'd0, p0_req_ready}, 32'd0);
      chk("rst p1_ready", {31'd0, p1_req_ready}, 32'd0);
      chk("rst mem strobes", {30'd0, mem_read, mem_write}, 32'd0);
      chk("rst resp", {30'd0, p0_resp_valid, p1_resp_valid}, 32'd0);
    end else begin
      e_r0 = 1'b0; e_r1 = 1'b0;
      if (cyc >= free_at) begin
        if (p0_req_valid && p1_req_valid) begin e_r1 = ptr_m; e_r0 = ~ptr_m; end
        else begin e_r0 = p0_req_valid; e_r1 = p1_req_valid; end
      end
      chk("p0_req_ready", {31'd0, p0_req_ready}, {31'd0, e_r0});
      chk("p1_req_ready", {31'd0, p1_req_ready}, {31'd0, e_r1});
      if (cyc == m_cyc) begin
        chk("mem_read", {31'd0, mem_read}, {31'd0, m_rd});
        chk("mem_write", {31'd0, mem_write}, {31'd0, m_wr});
        if (m_rd || m_wr) begin
          chk("mem_addr", mem_addr, m_addr);
          chk("mem_wdata", mem_wdata, m_wdata);
          chk("mem_func3", {29'd0, mem_func3}, {29'd0, m_f3});
        end
        if (m_wr) ref_mem[m_addr[5:0]] = merge(ref_mem[m_addr[5:0]], m_wdata, m_f3);
      end else begin
        chk("mem idle", {mem_addr[29:0], mem_read, mem_write}, 32'd0);
      end
      if (cyc == r_cyc) begin
        chk("resp valid", {30'd0, p1_resp_valid, p0_resp_valid}, r_port ? 32'd2 : 32'd1);
        chk("resp err", {30'd0, p1_resp_err, p0_resp_err}, {30'd0, r_port & r_err, ~r_port & r_err});
        chk("resp rdata", r_port ? p1_resp_rdata : p0_resp_rdata, r_rdata);
        chk("other rdata", r_port ? p0_resp_rdata : p1_resp_rdata, 32'd0);
      end else begin
        chk("resp idle", {30'd0, p1_resp_valid, p0_resp_valid}, 32'd0);
      end
      if (e_r0 || e_r1) begin
        w  = e_r1;
        we = w ? p1_req_we : p0_req_we;
        a  = w ? p1_req_addr : p0_req_addr;
        f  = w ? p1_req_func3 : p0_req_func3;
        er = (a >= 32'd40) || (f > 3'b010);
        m_cyc = cyc + 1; r_cyc = cyc + 2; free_at = cyc + 3; ptr_m = ~w;
        m_rd = ~er & ~we; m_wr = ~er & we;
        m_addr = a; m_f3 = f; m_wdata = w ? p1_req_wdata : p0_req_wdata;
        r_port = w; r_err = er;
        r_rdata = m_rd ? lane(ref_mem[a[5:0]], f) : 32'd0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Enter at +1 of a cycle with the request already driven; leave at +1 of t+1.
  task automatic wait_grant(input int port, output int t);
    t = -1;
    for (int n = 0; n < 16; n++) begin
      #2;
      if ((port == 0 && p0_req_ready) || (port == 1 && p1_req_ready)) begin
        t = cyc;
        break;
      end
      tick();
    end
    if (t < 0) chk("grant timeout", 32'd0, 32'd1);
    tick();
    if (port == 0) p0_req_valid = 1'b0;
    else p1_req_valid = 1'b0;
  endtask

  task automatic set_req(input int port, input logic w_e, input logic [31:0] ad,
                         input logic [31:0] wd, input logic [2:0] f3);
    if (port == 0) begin
      p0_req_valid = 1'b1; p0_req_we = w_e; p0_req_addr = ad; p0_req_wdata = wd; p0_req_func3 = f3;
    end else begin
      p1_req_valid = 1'b1; p1_req_we = w_e; p1_req_addr = ad; p1_req_wdata = wd; p1_req_func3 = f3;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int g0;
    int s1;
    for (int i = 0; i < 40; i++) begin mem[i] = 32'd0; ref_mem[i] = 32'd0; end
    mem[5] = 32'h8000_00F0; ref_mem[5] = 32'h8000_00F0;
    mem[9] = 32'h0BAD_F009; ref_mem[9] = 32'h0BAD_F009;
    tick(); tick();
    #2;
    chk("reset mem_write", {31'd0, mem_write}, 32'd0);
    chk("reset p0_resp_valid", {31'd0, p0_resp_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Simultaneous requests after reset: p0 first, p1 at t+3, p0 wins again.
    set_req(0, 1'b0, 32'd5, 32'd0, 3'b010);
    set_req(1, 1'b0, 32'd5, 32'd0, 3'b001);
    #2;
    chk("both: p0 granted", {31'd0, p0_req_ready}, 32'd1);
    chk("both: p1 waits", {31'd0, p1_req_ready}, 32'd0);
    tick(); p0_req_valid = 1'b0;
    tick(); tick();
    #2;
    chk("p1 granted at t+3", {31'd0, p1_req_ready}, 32'd1);
    tick(); p1_req_valid = 1'b0;
    tick();
    #2;
    chk("p1 LH resp_valid", {31'd0, p1_resp_valid}, 32'd1);
    chk("p1 LH rdata", p1_resp_rdata, 32'h0000_00F0);
    tick();
    set_req(0, 1'b0, 32'd5, 32'd0, 3'b010);
    set_req(1, 1'b0, 32'd5, 32'd0, 3'b010);
    #2;
    chk("repeat: p0 wins", {31'd0, p0_req_ready}, 32'd1);
    chk("repeat: p1 waits", {31'd0, p1_req_ready}, 32'd0);
    tick(); p0_req_valid = 1'b0;
    wait_grant(1, t);
    tick(); tick();

    // p0 LB of 0x8000_00F0 sign-extends to 0xFFFF_FFF0.
    set_req(0, 1'b0, 32'd5, 32'd0, 3'b000);
    wait_grant(0, t);
    #2;
    chk("LB mem_read at t+1", {31'd0, mem_read}, 32'd1);
    chk("LB mem_addr", mem_addr, 32'd5);
    tick(); #2;
    chk("LB resp_valid at t+2", {31'd0, p0_resp_valid}, 32'd1);
    chk("LB rdata", p0_resp_rdata, 32'hFFFF_FFF0);
    chk("LB err", {31'd0, p0_resp_err}, 32'd0);
    tick();

    // p1 store then p0 load back.
    set_req(1, 1'b1, 32'd7, 32'h1234_5678, 3'b010);
    wait_grant(1, t);
    #2;
    chk("SW mem_write", {31'd0, mem_write}, 32'd1);
    chk("SW mem_wdata", mem_wdata, 32'h1234_5678);
    tick(); #2;
    chk("SW strobe one cycle", {31'd0, mem_write}, 32'd0);
    chk("SW resp_valid", {31'd0, p1_resp_valid}, 32'd1);
    chk("SW rdata zero", p1_resp_rdata, 32'd0);
    tick();
    set_req(0, 1'b0, 32'd7, 32'd0, 3'b010);
    wait_grant(0, t);
    tick(); #2;
    chk("LW back", p0_resp_rdata, 32'h1234_5678);
    tick();

    // Errors: address out of range, then illegal func3.
    set_req(0, 1'b0, 32'd40, 32'd0, 3'b010);
    wait_grant(0, t);
    #2;
    chk("addr40 no strobe", {30'd0, mem_read, mem_write}, 32'd0);
    tick(); #2;
    chk("addr40 err", {31'd0, p0_resp_err}, 32'd1);
    chk("addr40 rdata", p0_resp_rdata, 32'd0);
    tick();
    set_req(1, 1'b0, 32'd3, 32'd0, 3'b011);
    wait_grant(1, t);
    #2;
    chk("f3=011 no strobe", {30'd0, mem_read, mem_write}, 32'd0);
    tick(); #2;
    chk("f3=011 err", {31'd0, p1_resp_err}, 32'd1);
    chk("f3=011 rdata", p1_resp_rdata, 32'd0);
    tick();

    // Reset during a store's ACCESS cycle drops it.
    set_req(0, 1'b1, 32'd9, 32'hDEAD_BEEF, 3'b010);
    wait_grant(0, t);
    #1;
    chk("pre-reset mem_write", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset drops mem_write", {31'd0, mem_write}, 32'd0);
    tick(); #2;
    chk("no resp after reset", {31'd0, p0_resp_valid}, 32'd0);
    chk("word 9 unchanged", mem[9], 32'h0BAD_F009);
    tick();
    rst_n = 1'b1;
    tick();
    set_req(0, 1'b0, 32'd9, 32'd0, 3'b010);
    wait_grant(0, t);
    tick(); #2;
    chk("post-reset LW 9", p0_resp_rdata, 32'h0BAD_F009);
    tick();

    // Fixed priority: both continuously valid for 12 cycles.
    fx_p0_valid = 1'b1; fx_p1_valid = 1'b1;
    g0 = 0; s1 = 0;
    for (int i = 0; i < 12; i++) begin
      #2;
      if (fx_p0_ready) g0++;
      if (fx_p1_ready) s1++;
      tick();
    end
    fx_p0_valid = 1'b0; fx_p1_valid = 1'b0;
    chk("fixed p0 grants", g0, 32'd4);
    chk("fixed p1 grants", s1, 32'd0);
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
